vp_row_scheduler: RTL and testbench

Sequences the video pixel pipeline for one scanline at a time.
- On a line-start strobe, it fetches one 32-bit charattr word per text column from text memory using a req/ack handshake.
- It drives the pipeline input stage with one enabled strobe per column.
- It collects the 64-bit pixel words returned by the pipeline and writes them in column order into the scanline buffer read by the video output stage.
- It sits between the text-memory arbiter and the pixel pipeline.

---
 rtl/vp_row_scheduler_pkg.sv | 22 ++
 rtl/vp_row_scheduler_if.sv | 15 +
 rtl/vp_row_collector.sv | 47 ++++
 rtl/vp_row_scheduler.sv | 107 ++++++++++
 tb/tb_vp_row_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vp_row_scheduler_pkg.sv
// rtl/vp_row_scheduler_pkg.sv - shared state encoding, widths and row clamp for the row scheduler
package vp_defs;

  localparam int CHARATTR_WIDTH = 32;
  localparam int PIXELS_WIDTH   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } row_state_t;

  // Rows past the glyph height repeat the bottom scanline instead of indexing garbage.
  function automatic logic [4:0] clamp_row(input logic [4:0] row, input int unsigned height);
    if ({27'd0, row} >= height) begin
      return 5'(height - 1);
    end
    return row;
  endfunction

endpackage

// File: rtl/vp_row_scheduler_if.sv
// rtl/vp_row_scheduler_if.sv - text-memory read bus between the row scheduler and the arbiter
interface vp_row_scheduler_if #(
  parameter int ADDR_WIDTH = 22
);
  import vp_defs::*;

  logic                      mem_rd_req;
  logic [ADDR_WIDTH-1:0]     mem_rd_address;
  logic                      mem_rd_ack;
  logic [CHARATTR_WIDTH-1:0] mem_rd_data;

  modport master (output mem_rd_req, output mem_rd_address, input mem_rd_ack, input mem_rd_data);
  modport slave  (input mem_rd_req, input mem_rd_address, output mem_rd_ack, output mem_rd_data);

endinterface

// File: rtl/vp_row_collector.sv
// rtl/vp_row_collector.sv - return path: writes pipeline pixels into the line buffer in column order
module vp_row_collector
  import vp_defs::*;
#(
  parameter int COLUMNS   = 80,
  parameter int COL_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    clear,
  input  logic                    vp_enable,
  input  logic [PIXELS_WIDTH-1:0] vp_pixels,
  output logic                    lb_wr_en,
  output logic [COL_WIDTH-1:0]    lb_wr_address,
  output logic [PIXELS_WIDTH-1:0] lb_wr_data,
  output logic                    all_returned
);

  localparam logic [COL_WIDTH-1:0] COL_COUNT = COL_WIDTH'(COLUMNS);

  logic [COL_WIDTH-1:0] ret_cnt;
  logic                 accept;

  // Returns beyond the line length or outside a line are dropped silently.
  assign accept       = active && vp_enable && (ret_cnt < COL_COUNT);
  assign all_returned = (ret_cnt == COL_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_cnt       <= '0;
      lb_wr_en      <= 1'b0;
      lb_wr_address <= '0;
      lb_wr_data    <= '0;
    end else begin
      lb_wr_en <= accept;
      if (clear) begin
        ret_cnt <= '0;
      end else if (accept) begin
        lb_wr_address <= ret_cnt;
        lb_wr_data    <= vp_pixels;
        ret_cnt       <= ret_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vp_row_scheduler.sv
// rtl/vp_row_scheduler.sv - per-scanline charattr fetch, pipeline issue and line-buffer fill sequencer
module vp_row_scheduler
  import vp_defs::*;
#(
  parameter int COLUMNS     = 80,
  parameter int COL_WIDTH   = 7,
  parameter int ADDR_WIDTH  = 22,
  parameter int CHAR_HEIGHT = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [ADDR_WIDTH-1:0]     row_base_address,
  input  logic [4:0]                char_row,
  input  logic [3:0]                ypos,
  vp_row_scheduler_if.master        mem,
  output logic [CHARATTR_WIDTH-1:0] vp_charattr,
  output logic [4:0]                vp_char_row,
  output logic [3:0]                vp_ypos,
  output logic                      vp_enabled,
  input  logic [PIXELS_WIDTH-1:0]   vp_pixels,
  input  logic                      vp_enable,
  output logic                      lb_wr_en,
  output logic [COL_WIDTH-1:0]      lb_wr_address,
  output logic [PIXELS_WIDTH-1:0]   lb_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  row_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [COL_WIDTH-1:0]  issue_cnt;
  logic                  all_returned;
  logic                  start_ok;
  logic                  fetch_ack;
  logic                  last_issue;

  assign start_ok           = line_start && (state == ST_IDLE);
  assign fetch_ack          = (state == ST_FETCH) && mem.mem_rd_ack;
  assign last_issue         = (issue_cnt == COL_WIDTH'(COLUMNS - 1));
  assign busy               = (state != ST_IDLE);
  assign done               = (state == ST_DONE);
  assign mem.mem_rd_req     = (state == ST_FETCH);
  assign mem.mem_rd_address = base_addr + ADDR_WIDTH'(issue_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (line_start) state_nxt = ST_FETCH;
      ST_FETCH: if (fetch_ack && last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (all_returned) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // DONE still counts as busy, so a line_start coinciding with done is an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_addr   <= '0;
      issue_cnt   <= '0;
      vp_charattr <= '0;
      vp_char_row <= '0;
      vp_ypos     <= '0;
      vp_enabled  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun    <= line_start && busy;
      vp_enabled <= fetch_ack;
      if (start_ok) begin
        base_addr   <= row_base_address;
        issue_cnt   <= '0;
        vp_char_row <= clamp_row(char_row, CHAR_HEIGHT);
        vp_ypos     <= ypos;
      end else if (fetch_ack) begin
        vp_charattr <= mem.mem_rd_data;
        issue_cnt   <= issue_cnt + 1'b1;
      end
    end
  end

  vp_row_collector #(
    .COLUMNS   (COLUMNS),
    .COL_WIDTH (COL_WIDTH)
  ) u_collector (
    .clk           (clk),
    .reset         (reset),
    .active        (busy),
    .clear         (start_ok),
    .vp_enable     (vp_enable),
    .vp_pixels     (vp_pixels),
    .lb_wr_en      (lb_wr_en),
    .lb_wr_address (lb_wr_address),
    .lb_wr_data    (lb_wr_data),
    .all_returned  (all_returned)
  );

endmodule

// File: tb/tb_vp_row_scheduler.sv
// tb/tb_vp_row_scheduler.sv - scoreboard bench for vp_row_scheduler with memory and pipeline models
module tb_vp_row_scheduler;
  import vp_defs::*;

  localparam int COLUMNS     = 4;
  localparam int COL_WIDTH   = 7;
  localparam int ADDR_WIDTH  = 22;
  localparam int CHAR_HEIGHT = 20;
  localparam int LAT         = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  line_start = 1'b0;
  logic [ADDR_WIDTH-1:0] row_base_address = '0;
  logic [4:0]            char_row = '0;
  logic [3:0]            ypos = '0;
  logic [31:0]           vp_charattr;
  logic [4:0]            vp_char_row;
  logic [3:0]            vp_ypos;
  logic                  vp_enabled;
  logic [63:0]           vp_pixels;
  logic                  vp_enable;
  logic                  lb_wr_en;
  logic [COL_WIDTH-1:0]  lb_wr_address;
  logic [63:0]           lb_wr_data;
  logic                  busy, done, overrun;

  logic        mdl_ack = 1'b0, stray_ack = 1'b0, mdl_en = 1'b0, stray_en = 1'b0;
  logic [31:0] mdl_data = '0;
  logic [63:0] mdl_pix = '0;

  vp_row_scheduler_if #(.ADDR_WIDTH(ADDR_WIDTH)) mem_if ();
  assign mem_if.mem_rd_ack  = mdl_ack | stray_ack;
  assign mem_if.mem_rd_data = mdl_data;
  assign vp_enable          = mdl_en | stray_en;
  assign vp_pixels          = mdl_pix;

  vp_row_scheduler #(
    .COLUMNS(COLUMNS), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CHAR_HEIGHT(CHAR_HEIGHT)
  ) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .row_base_address(row_base_address),
    .char_row(char_row), .ypos(ypos), .mem(mem_if), .vp_charattr(vp_charattr),
    .vp_char_row(vp_char_row), .vp_ypos(vp_ypos), .vp_enabled(vp_enabled), .vp_pixels(vp_pixels),
    .vp_enable(vp_enable), .lb_wr_en(lb_wr_en), .lb_wr_address(lb_wr_address),
    .lb_wr_data(lb_wr_data), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int en_cnt = 0, done_cnt = 0, ovr_cnt = 0, lb_cnt = 0, nacks = 0;
  int ack_first = 0, ack_last = 0, done_cyc = 0, start_cyc = 0;
  int ack_limit = 1000000, acks_given = 0, wait_left = 0;
  bit rand_waits = 1'b0;

  logic [ADDR_WIDTH-1:0]       exp_addr[$];
  logic [31:0]                 exp_attr[$];
  logic [COL_WIDTH+63:0]       exp_lb[$];

  function automatic logic [31:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
    return 32'h5A00_0000 ^ {10'd0, a} ^ {a[7:0], 24'd0};
  endfunction

  function automatic logic [63:0] pix_of(input logic [31:0] c);
    return {~c, c ^ 32'h1357_9BDF};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Text memory: acks a pending request after an optional random wait, up to ack_limit acks.
  always @(posedge clk) begin
    #1;
    mdl_ack = 1'b0;
    if (reset && mem_if.mem_rd_req) begin
      if (wait_left > 0) begin
        wait_left--;
      end else if (acks_given < ack_limit) begin
        mdl_ack  = 1'b1;
        mdl_data = mem_word(mem_if.mem_rd_address);
        acks_given++;
        wait_left = rand_waits ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  // Pixel pipeline with fixed latency LAT from vp_enabled to vp_enable.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pd[LAT];
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      pv     = '0;
      mdl_en = 1'b0;
    end else begin
      mdl_en  = pv[LAT-1];
      mdl_pix = pix_of(pd[LAT-1]);
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = vp_enabled;
      pd[0] = vp_charattr;
    end
  end

  // Monitor: compares every observed DUT transaction against the scoreboard queues.
  logic                  prev_wait = 1'b0;
  logic [ADDR_WIDTH-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && mem_if.mem_rd_req)
        check("addr_stable", mem_if.mem_rd_address, prev_addr);
      prev_wait = mem_if.mem_rd_req && !mem_if.mem_rd_ack;
      prev_addr = mem_if.mem_rd_address;
      if (mem_if.mem_rd_req && mem_if.mem_rd_ack) begin
        if (nacks == 0) ack_first = cyc;
        ack_last = cyc;
        nacks++;
        if (exp_addr.size() == 0) check("addr_unexpected", mem_if.mem_rd_address, 128'hDEAD);
        else check("rd_address", mem_if.mem_rd_address, exp_addr.pop_front());
      end
      if (vp_enabled) begin
        en_cnt++;
        if (exp_attr.size() == 0) check("charattr_unexpected", vp_charattr, 128'hDEAD);
        else check("vp_charattr", vp_charattr, exp_attr.pop_front());
      end
      if (lb_wr_en) begin
        lb_cnt++;
        if (exp_lb.size() == 0) check("lb_unexpected", {lb_wr_address, lb_wr_data}, 128'hDEAD);
        else check("lb_write", {lb_wr_address, lb_wr_data}, exp_lb.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
    end
  end

  task automatic push_col(input int col, input logic [ADDR_WIDTH-1:0] a, input bit with_lb);
    exp_addr.push_back(a);
    exp_attr.push_back(mem_word(a));
    if (with_lb) exp_lb.push_back({COL_WIDTH'(col), pix_of(mem_word(a))});
  endtask

  task automatic pulse_start(input logic [ADDR_WIDTH-1:0] base, input logic [4:0] row, input logic [3:0] yp);
    @(posedge clk);
    #1;
    line_start = 1'b1;
    row_base_address = base;
    char_row = row;
    ypos = yp;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) check({name, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check({name, "_addr_q"}, exp_addr.size(), 0);
    check({name, "_attr_q"}, exp_attr.size(), 0);
    check({name, "_lb_q"}, exp_lb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time %0t required completion", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0, o0, e0, l0, n;
    #1;
    check("reset_outputs", {mem_if.mem_rd_req, mem_if.mem_rd_address, vp_enabled, lb_wr_en, busy, done, overrun, vp_char_row, vp_ypos}, 0);
    check("reset_data", {vp_charattr, lb_wr_data}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Zero-wait acks, L=5: timing of first request, burst and done.
    nacks = 0; en_cnt = 0; d0 = done_cnt;
    for (int c = 0; c < COLUMNS; c++) push_col(c, 22'h100 + 22'(c), 1'b1);
    pulse_start(22'h100, 5'd3, 4'd5);
    wait_done(d0, "t1");
    check("t1_done_latency", done_cyc - start_cyc, 12);
    check("t1_first_req", ack_first - start_cyc, 1);
    check("t1_ack_span", ack_last - ack_first, 3);
    check("t1_enabled", en_cnt, 4);
    check("t1_char_row", vp_char_row, 3);
    check("t1_ypos", vp_ypos, 5);
    check("t1_done_count", done_cnt - d0, 1);
    check_drained("t1");

    // Random 0..3 wait states.
    rand_waits = 1'b1; wait_left = 2; en_cnt = 0; d0 = done_cnt;
    for (int c = 0; c < COLUMNS; c++) push_col(c, 22'h2A0 + 22'(c), 1'b1);
    pulse_start(22'h2A0, 5'd7, 4'd1);
    wait_done(d0, "t2");
    check("t2_enabled", en_cnt, 4);
    check_drained("t2");
    rand_waits = 1'b0; wait_left = 0;

    // Second line_start mid-line is an overrun and is otherwise ignored.
    en_cnt = 0; d0 = done_cnt; o0 = ovr_cnt; l0 = lb_cnt;
    for (int c = 0; c < COLUMNS; c++) push_col(c, 22'h200 + 22'(c), 1'b1);
    pulse_start(22'h200, 5'd2, 4'd2);
    pulse_start(22'h300, 5'd9, 4'd9);
    wait_done(d0, "t3");
    repeat (10) @(negedge clk);
    check("t3_overrun", ovr_cnt - o0, 1);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_writes", lb_cnt - l0, 4);
    check("t3_char_row", vp_char_row, 2);
    check_drained("t3");

    // Address wrap at the top of the 22-bit space.
    d0 = done_cnt;
    push_col(0, 22'h3FFFFE, 1'b1);
    push_col(1, 22'h3FFFFF, 1'b1);
    push_col(2, 22'h000000, 1'b1);
    push_col(3, 22'h000001, 1'b1);
    pulse_start(22'h3FFFFE, 5'd0, 4'd0);
    wait_done(d0, "t4");
    check_drained("t4");

    // Reset while waiting on column 2; late ack and vp_enable must be ignored.
    acks_given = 0; ack_limit = 2; e0 = en_cnt;
    push_col(0, 22'h080, 1'b0);
    push_col(1, 22'h081, 1'b0);
    pulse_start(22'h080, 5'd4, 4'd4);
    n = 0;
    while (acks_given < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_acks_reached", acks_given, 2);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_reset_outputs", {mem_if.mem_rd_req, mem_if.mem_rd_address, vp_enabled, lb_wr_en, busy, done, overrun, vp_char_row, vp_ypos}, 0);
    check("t5_reset_data", {vp_charattr, lb_wr_data, lb_wr_address}, 0);
    check("t5_enabled_before", en_cnt - e0, 2);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ack_limit = 1000000;
    l0 = lb_cnt; e0 = en_cnt;
    stray_ack = 1'b1; stray_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_ack = 1'b0; stray_en = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_writes", lb_cnt - l0, 0);
    check("t5_no_enabled", en_cnt - e0, 0);
    check("t5_idle", busy, 0);
    check_drained("t5");

    // Clean line after reset with an out-of-range char_row, then a stray idle vp_enable.
    en_cnt = 0; d0 = done_cnt; l0 = lb_cnt;
    for (int c = 0; c < COLUMNS; c++) push_col(c, 22'h040 + 22'(c), 1'b1);
    pulse_start(22'h040, 5'd25, 4'd9);
    check("t6_char_row_clamped", vp_char_row, 19);
    wait_done(d0, "t6");
    check("t6_enabled", en_cnt, 4);
    check("t6_writes", lb_cnt - l0, 4);
    check("t6_ypos", vp_ypos, 9);
    check_drained("t6");
    l0 = lb_cnt;
    @(posedge clk);
    #1 stray_en = 1'b1;
    @(posedge clk);
    #1 stray_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_stray", lb_cnt - l0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
